enemy_control: RTL and testbench

ENEMY_CONTROL -- requirements
Module: enemy_control

---
 rtl/punchout_pkg.sv | 40 ++++
 rtl/lfsr8.sv | 20 ++
 rtl/enemy_control.sv | 156 +++++++++++++++
 tb/tb_enemy_control.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/punchout_pkg.sv
// Shared types and constants for the punch-out enemy controller.
// Holds the FSM encoding, the lane codes and the LFSR seed/taps.
package punchout_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_WINDUP,
    S_STRIKE,
    S_RECOVER,
    S_WIN,
    S_LOSE
  } state_t;

  localparam logic [1:0] LANE_L = 2'd0;
  localparam logic [1:0] LANE_C = 2'd1;
  localparam logic [1:0] LANE_R = 2'd2;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // taps 8,6,5,4 -> bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [1:0] lane_of(
    input logic [1:0] v
  );
    return (v == 2'b11) ? LANE_C : v;
  endfunction

  // {windup, attack, vulnerable, game_over, player_won}
  function automatic logic [4:0] flags_of(
    input state_t s
  );
    return {s == S_WINDUP,
            s == S_STRIKE,
            s == S_RECOVER,
            (s == S_WIN) || (s == S_LOSE),
            s == S_WIN};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR used to pick the enemy lane.
// Free-running: advances on every clock.
module lfsr8
  import punchout_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  output logic [7:0] q
);

  logic fb;

  assign fb = ^(q & LFSR_TAPS);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) q <= LFSR_SEED;
    else         q <= {q[6:0], fb};
  end

endmodule

// File: rtl/enemy_control.sv
// Enemy behaviour FSM: move, telegraph, strike, recover.
// Tracks both health pools and reports the bout outcome.
module enemy_control
  import punchout_pkg::*;
#(
  parameter logic [7:0] IDLE_TICKS    = 8'd45,
  parameter logic [7:0] WINDUP_TICKS  = 8'd30,
  parameter logic [7:0] STRIKE_TICKS  = 8'd10,
  parameter logic [7:0] RECOVER_TICKS = 8'd20,
  parameter logic [3:0] ENEMY_HP      = 4'd8,
  parameter logic [1:0] PLAYER_HP     = 2'd3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       tick,
  input  logic [1:0] player_lane,
  input  logic       player_punch,
  output logic [1:0] x_pos,
  output logic       speed,
  output logic       windup,
  output logic       attack,
  output logic       vulnerable,
  output logic       player_hit,
  output logic       enemy_hit,
  output logic [3:0] enemy_hp,
  output logic [1:0] player_hp,
  output logic       game_over,
  output logic       player_won
);

  localparam logic [3:0] HALF = ENEMY_HP >> 1;
  localparam logic SPD_FULL = (ENEMY_HP <= HALF);

  function automatic logic [7:0] reload(
    input logic [7:0] n,
    input logic       fast
  );
    logic [7:0] t;
    t = fast ? (n >> 1) : n;
    if (t == 8'd0) t = 8'd1;
    return t - 8'd1;
  endfunction

  state_t     state;
  logic [7:0] rnd;
  logic [7:0] cnt;
  logic [3:0] hp_nxt;
  logic       expire;
  logic       punched;
  logic       spd_now;
  logic       spd_nxt;

  lfsr8 u_lfsr (
    .clock  (clock),
    .resetn (resetn),
    .q      (rnd)
  );

  assign expire  = tick && (cnt == 8'd0);
  assign punched = player_punch && (state == S_RECOVER)
                && (enemy_hp != 4'd0);
  assign hp_nxt  = enemy_hp - {3'd0, punched};
  assign spd_now = (enemy_hp <= HALF);
  assign spd_nxt = (hp_nxt <= HALF);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      x_pos      <= LANE_C;
      enemy_hp   <= ENEMY_HP;
      player_hp  <= PLAYER_HP;
      speed      <= 1'b0;
      player_hit <= 1'b0;
      enemy_hit  <= 1'b0;
      {windup, attack, vulnerable, game_over, player_won} <= '0;
    end else begin
      player_hit <= 1'b0;
      enemy_hit  <= 1'b0;
      unique case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            state     <= S_MOVE;
            enemy_hp  <= ENEMY_HP;
            player_hp <= PLAYER_HP;
            x_pos     <= lane_of(rnd[1:0]);
            cnt       <= reload(IDLE_TICKS, SPD_FULL);
            speed     <= SPD_FULL;
            {windup, attack, vulnerable, game_over, player_won}
              <= flags_of(S_MOVE);
          end
        end
        default: begin
          if (tick && cnt != 8'd0) cnt <= cnt - 8'd1;
          if (enemy_hp == 4'd0) begin
            state <= S_WIN;
            speed <= 1'b0;
            {windup, attack, vulnerable, game_over, player_won}
              <= flags_of(S_WIN);
          end else if (player_hp == 2'd0) begin
            state <= S_LOSE;
            speed <= 1'b0;
            {windup, attack, vulnerable, game_over, player_won}
              <= flags_of(S_LOSE);
          end else begin
            unique case (state)
              S_MOVE: if (expire) begin
                state <= S_WINDUP;
                cnt   <= reload(WINDUP_TICKS, spd_now);
                speed <= spd_now;
                {windup, attack, vulnerable, game_over, player_won}
                  <= flags_of(S_WINDUP);
              end
              S_WINDUP: if (expire) begin
                state <= S_STRIKE;
                cnt   <= reload(STRIKE_TICKS, spd_now);
                speed <= spd_now;
                {windup, attack, vulnerable, game_over, player_won}
                  <= flags_of(S_STRIKE);
                if (player_lane == x_pos) begin
                  player_hit <= 1'b1;
                  player_hp  <= player_hp - 2'd1;
                end
              end
              S_STRIKE: if (expire) begin
                state <= S_RECOVER;
                cnt   <= reload(RECOVER_TICKS, spd_now);
                speed <= spd_now;
                {windup, attack, vulnerable, game_over, player_won}
                  <= flags_of(S_RECOVER);
              end
              S_RECOVER: begin
                if (punched) begin
                  enemy_hit <= 1'b1;
                  enemy_hp  <= hp_nxt;
                end
                // a killing blow holds here so the next cycle goes to WIN
                if (expire && hp_nxt != 4'd0) begin
                  state <= S_MOVE;
                  x_pos <= lane_of(rnd[1:0]);
                  cnt   <= reload(IDLE_TICKS, spd_nxt);
                  speed <= spd_nxt;
                  {windup, attack, vulnerable, game_over, player_won}
                    <= flags_of(S_MOVE);
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_control.sv
// Directed bench for enemy_control with short tick counts.
// Lane expectations come from an independent LFSR model.
module tb_enemy_control;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] player_lane = 2'd3;
  logic       player_punch = 1'b0;
  logic [1:0] x_pos;
  logic       speed, windup, attack, vulnerable;
  logic       player_hit, enemy_hit;
  logic [3:0] enemy_hp;
  logic [1:0] player_hp;
  logic       game_over, player_won;

  int errors = 0;
  int checks = 0;

  logic [7:0] m;
  logic [1:0] exp_x;

  enemy_control #(
    .IDLE_TICKS    (8'd2),
    .WINDUP_TICKS  (8'd2),
    .STRIKE_TICKS  (8'd1),
    .RECOVER_TICKS (8'd2),
    .ENEMY_HP      (4'd2),
    .PLAYER_HP     (2'd1)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .start        (start),
    .tick         (tick),
    .player_lane  (player_lane),
    .player_punch (player_punch),
    .x_pos        (x_pos),
    .speed        (speed),
    .windup       (windup),
    .attack       (attack),
    .vulnerable   (vulnerable),
    .player_hit   (player_hit),
    .enemy_hit    (enemy_hit),
    .enemy_hp     (enemy_hp),
    .player_hp    (player_hp),
    .game_over    (game_over),
    .player_won   (player_won)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) m <= 8'hA5;
    else         m <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
  end

  function automatic logic [1:0] blane(input logic [7:0] v);
    return (v[1:0] == 2'd3) ? 2'd1 : v[1:0];
  endfunction

  task automatic check(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] expv
  );
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // one tick every 4 clocks; returns at the negedge after it is taken
  task automatic tk(input logic punch);
    repeat (2) @(negedge clock);
    @(negedge clock);
    exp_x = blane(m);
    tick = 1'b1;
    player_punch = punch;
    @(negedge clock);
    tick = 1'b0;
    player_punch = 1'b0;
  endtask

  task automatic punch_once();
    @(negedge clock);
    player_punch = 1'b1;
    @(negedge clock);
    player_punch = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clock);
    exp_x = blane(m);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    int bad3;
    int xbad;
    int moves;
    logic [1:0] lane_pre;
    logic pv;

    repeat (3) @(negedge clock);
    check("rst_x", {6'd0, x_pos}, 8'd1);
    check("rst_ehp", {4'd0, enemy_hp}, 8'd2);
    check("rst_php", {6'd0, player_hp}, 8'd1);
    check("rst_flags", {3'd0, windup, attack, vulnerable,
          game_over, player_won}, 8'd0);
    check("rst_speed", {7'd0, speed}, 8'd0);
    resetn = 1'b1;

    // bout A: player out of lane, enemy loses
    start_pulse();
    check("a_move_x", {6'd0, x_pos}, {6'd0, exp_x});
    check("a_move_flags", {5'd0, windup, attack, vulnerable}, 8'd0);
    tk(1'b0);
    check("a_t1_windup", {7'd0, windup}, 8'd0);
    tk(1'b0);
    check("a_t2_windup", {7'd0, windup}, 8'd1);
    punch_once();
    check("a_wu_punch_hit", {7'd0, enemy_hit}, 8'd0);
    check("a_wu_punch_hp", {4'd0, enemy_hp}, 8'd2);
    tk(1'b0);
    check("a_t3_windup", {7'd0, windup}, 8'd1);
    tk(1'b0);
    check("a_t4_attack", {6'd0, attack, windup}, 8'd2);
    check("a_t4_phit", {7'd0, player_hit}, 8'd0);
    punch_once();
    check("a_st_punch_hit", {7'd0, enemy_hit}, 8'd0);
    check("a_st_punch_hp", {4'd0, enemy_hp}, 8'd2);
    tk(1'b0);
    check("a_t5_vuln", {6'd0, vulnerable, attack}, 8'd2);
    punch_once();
    check("a_rc_punch_hit", {7'd0, enemy_hit}, 8'd1);
    check("a_rc_punch_hp", {4'd0, enemy_hp}, 8'd1);
    @(negedge clock);
    check("a_hit_pulse", {7'd0, enemy_hit}, 8'd0);
    tk(1'b0);
    check("a_t6_vuln", {7'd0, vulnerable}, 8'd1);
    tk(1'b0);
    check("a_t7_vuln", {7'd0, vulnerable}, 8'd0);
    check("a_t7_speed", {7'd0, speed}, 8'd1);
    check("a_t7_x", {6'd0, x_pos}, {6'd0, exp_x});
    tk(1'b0);
    check("a_t8_fast_windup", {7'd0, windup}, 8'd1);
    tk(1'b0);
    check("a_t9_fast_attack", {7'd0, attack}, 8'd1);
    tk(1'b0);
    check("a_t10_fast_vuln", {7'd0, vulnerable}, 8'd1);
    tk(1'b1);
    check("a_t11_ehit", {7'd0, enemy_hit}, 8'd1);
    check("a_t11_ehp", {4'd0, enemy_hp}, 8'd0);
    check("a_t11_not_move", {7'd0, vulnerable}, 8'd1);
    check("a_t11_gover", {7'd0, game_over}, 8'd0);
    @(negedge clock);
    check("a_win", {6'd0, game_over, player_won}, 8'd3);
    check("a_win_vuln", {7'd0, vulnerable}, 8'd0);
    check("a_win_speed", {7'd0, speed}, 8'd0);
    repeat (4) @(negedge clock);
    check("a_win_hold", {6'd0, game_over, player_won}, 8'd3);

    // bout B: player in the strike lane, player loses
    start_pulse();
    check("b_move_x", {6'd0, x_pos}, {6'd0, exp_x});
    check("b_ehp", {4'd0, enemy_hp}, 8'd2);
    check("b_php", {6'd0, player_hp}, 8'd1);
    check("b_gover", {6'd0, game_over, player_won}, 8'd0);
    check("b_speed", {7'd0, speed}, 8'd0);
    player_lane = exp_x;
    tk(1'b0);
    start_pulse();
    tk(1'b0);
    check("b_start_ignored", {7'd0, windup}, 8'd1);
    tk(1'b0);
    tk(1'b0);
    check("b_attack", {7'd0, attack}, 8'd1);
    check("b_phit", {7'd0, player_hit}, 8'd1);
    check("b_php0", {6'd0, player_hp}, 8'd0);
    @(negedge clock);
    check("b_lose", {6'd0, game_over, player_won}, 8'd2);
    check("b_phit_pulse", {7'd0, player_hit}, 8'd0);
    check("b_lose_attack", {7'd0, attack}, 8'd0);

    // bout C: reset in the middle of windup
    player_lane = 2'd3;
    start_pulse();
    tk(1'b0);
    tk(1'b0);
    check("c_windup", {7'd0, windup}, 8'd1);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    check("c_rst_flags", {3'd0, windup, attack, vulnerable,
          game_over, player_won}, 8'd0);
    check("c_rst_x", {6'd0, x_pos}, 8'd1);
    check("c_rst_hp", {2'd0, enemy_hp, player_hp}, 8'h09);
    check("c_rst_hits", {6'd0, player_hit, enemy_hit}, 8'd0);
    @(negedge clock);
    resetn = 1'b1;

    // free-running bouts with a tick every clock
    start_pulse();
    check("c_move_x", {6'd0, x_pos}, {6'd0, exp_x});
    bad3 = 0;
    xbad = 0;
    moves = 0;
    tick = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      lane_pre = blane(m);
      pv = vulnerable;
      @(negedge clock);
      if (x_pos == 2'd3) bad3++;
      if (pv && !vulnerable) begin
        moves++;
        if (x_pos !== lane_pre) xbad++;
      end
    end
    tick = 1'b0;
    check("c_never_lane3", bad3[7:0], 8'd0);
    check("c_lane_model", xbad[7:0], 8'd0);
    check("c_moves", {7'd0, moves >= 140}, 8'd1);
    check("c_no_gover", {7'd0, game_over}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
